// File: rtl/carryselect_accumulator.sv
// Carry-select adder plus a packet accumulator that sums LEN stream operands onto an initial value.
// Optional saturating arithmetic: define CARRYSELECT_ACCUM_SATURATE_EN.
module carryselect_adder #(
    parameter int N = 32,
    parameter int M = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    localparam int NB = N / M;

    logic [NB:0] c;

    assign c[0]  = c_in;
    assign c_out = c[NB];

    genvar i;
    generate
        for (i = 0; i < NB; i++) begin : g_blk
            logic [M:0] s0;
            logic [M:0] s1;

            // Both carry-in cases are precomputed; the incoming carry only selects.
            assign s0 = {1'b0, a[i*M +: M]} + {1'b0, b[i*M +: M]};
            assign s1 = {1'b0, a[i*M +: M]} + {1'b0, b[i*M +: M]} + {{M{1'b0}}, 1'b1};

            assign sum[i*M +: M] = c[i] ? s1[M-1:0] : s0[M-1:0];
            assign c[i+1]        = c[i] ? s1[M] : s0[M];
        end
    endgenerate
endmodule

module carryselect_accumulator #(
    parameter int N   = 32,
    parameter int M   = 8,
    parameter int LEN = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] init,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_carry,
    output logic         busy
);
    localparam int CW = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic [N-1:0]  sum;
    logic          c_out;
    logic          beat;
    logic          last;

    carryselect_adder #(
        .N(N),
        .M(M)
    ) u_adder (
        .a    (acc),
        .b    (in_data),
        .c_in (1'b0),
        .sum  (sum),
        .c_out(c_out)
    );

    assign beat = in_valid & in_ready;
    assign last = (cnt == CW'(LEN - 1));

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                acc <= init;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (beat) begin
                cnt <= cnt + CW'(1);
                ovf <= ovf | c_out;
`ifdef CARRYSELECT_ACCUM_SATURATE_EN
                // Saturation is sticky for the rest of the packet.
                acc <= (c_out | ovf) ? '1 : sum;
`else
                acc <= sum;
`endif
            end
        end
    end

    assign out_sum   = acc;
    assign out_carry = ovf;
    assign busy      = (state == ACCUM) || (state == DONE);
endmodule

// File: tb/tb_carryselect_accumulator.sv
// Self-checking bench for carryselect_accumulator: table of packets, scoreboard queue,
// plus hand-written reset, idle and mid-packet sequences.
module tb_carryselect_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] init;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
    } res_t;

    res_t sb[$];

    typedef struct {
        logic [31:0]       init;
        logic [3:0][31:0]  ops;
        int                gap;
        int                bp;
        bit                spulse;
        logic [31:0]       esum;
        logic              ecarry;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    carryselect_accumulator #(.N(32), .M(8), .LEN(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .init     (init),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry),
        .busy     (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] o0,
                                input logic [31:0] o1, input logic [31:0] o2,
                                input logic [31:0] o3, input int g, input int b,
                                input bit sp, input logic [31:0] es, input logic ec);
        vec_t v;
        v.init = i;
        v.ops[0] = o0;
        v.ops[1] = o1;
        v.ops[2] = o2;
        v.ops[3] = o3;
        v.gap = g;
        v.bp = b;
        v.spulse = sp;
        v.esum = es;
        v.ecarry = ec;
        return v;
    endfunction

    // Reference accumulation used for the randomized packets.
    function automatic res_t model(input logic [31:0] i, input logic [3:0][31:0] ops);
        res_t r;
        logic [32:0] t;
        r.sum = i;
        r.carry = 1'b0;
        for (int k = 0; k < 4; k++) begin
            t = {1'b0, r.sum} + {1'b0, ops[k]};
`ifdef CARRYSELECT_ACCUM_SATURATE_EN
            r.sum = (t[32] | r.carry) ? 32'hFFFF_FFFF : t[31:0];
`else
            r.sum = t[31:0];
`endif
            r.carry = r.carry | t[32];
        end
        return r;
    endfunction

    task automatic run_pkt(input vec_t v);
        res_t exp;
        logic [31:0] held;
        sb.push_back('{sum: v.esum, carry: v.ecarry});
        start = 1'b1;
        init = v.init;
        tick();
        start = 1'b0;
        init = 32'hDEAD_BEEF;
        check("in_ready_after_start", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < v.gap; g++) begin
                in_valid = 1'b0;
                in_data = 32'h5A5A_5A5A;
                start = v.spulse;
                tick();
                check("in_ready_gap", {31'b0, in_ready}, 32'd1);
            end
            in_valid = 1'b1;
            in_data = v.ops[k];
            start = v.spulse;
            if (k < 3) begin
                check("no_valid_early", {31'b0, out_valid}, 32'd0);
            end
            tick();
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("out_valid_latency", {31'b0, out_valid}, 32'd1);
        check("in_ready_done", {31'b0, in_ready}, 32'd0);
        held = out_sum;
        for (int b = 0; b < v.bp; b++) begin
            out_ready = 1'b0;
            tick();
            check("bp_valid_held", {31'b0, out_valid}, 32'd1);
            check("bp_sum_held", out_sum, held);
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL handshake: out_valid 0, want 1");
        end else begin
            exp = sb.pop_front();
            check("out_sum", out_sum, exp.sum);
            check("out_carry", {31'b0, out_carry}, {31'b0, exp.carry});
        end
        out_ready = 1'b1;
        // start coinciding with DONE completion must not begin a packet
        start = 1'b1;
        init = 32'h1234_5678;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("idle_after_hs", {31'b0, busy}, 32'd0);
        check("out_valid_drop", {31'b0, out_valid}, 32'd0);
        check("acc_retained", out_sum, held);
        tick();
        check("start_in_done_ignored", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [3:0][31:0] rops;
        res_t r;
        vec_t v;

        rst = 1'b1;
        start = 1'b0;
        init = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;

        vecs.push_back(mk(32'd10, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 0, 32'd20, 1'b0));
        vecs.push_back(mk(32'd10, 32'd1, 32'd2, 32'd3, 32'd4, 3, 4, 0, 32'd20, 1'b0));
`ifdef CARRYSELECT_ACCUM_SATURATE_EN
        vecs.push_back(mk(32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1'b1));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                          32'hFFFF_FFFF, 1, 0, 0, 32'hFFFF_FFFF, 1'b1));
`else
        vecs.push_back(mk(32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0, 1, 0, 32'h0000_0010, 1'b1));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                          32'hFFFF_FFFF, 1, 0, 0, 32'hFFFF_FFFB, 1'b1));
`endif
        vecs.push_back(mk(32'd0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_FF00,
                          32'h0000_0100, 0, 0, 0, 32'h0001_0100, 1'b0));
        vecs.push_back(mk(32'd100, 32'd1, 32'd1, 32'd1, 32'd1, 1, 2, 1, 32'd104, 1'b0));

        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 32'd5;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("idle_out_valid", {31'b0, out_valid}, 32'd0);
            check("idle_in_ready", {31'b0, in_ready}, 32'd0);
            check("idle_busy", {31'b0, busy}, 32'd0);
            check("idle_out_sum", out_sum, 32'd0);
            check("idle_out_carry", {31'b0, out_carry}, 32'd0);
        end
        in_valid = 1'b0;

        foreach (vecs[k]) run_pkt(vecs[k]);

        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 4; k++) rops[k] = $urandom;
            v = mk($urandom, rops[0], rops[1], rops[2], rops[3],
                   $urandom_range(0, 2), $urandom_range(0, 2), 0, 32'd0, 1'b0);
            r = model(v.init, rops);
            v.esum = r.sum;
            v.ecarry = r.carry;
            run_pkt(v);
        end

        // reset after two beats discards the packet
        start = 1'b1;
        init = 32'd7;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'd3;
        tick();
        tick();
        in_valid = 1'b0;
        check("mid_acc_progress", out_sum, 32'd13);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_acc", out_sum, 32'd0);
        check("mid_rst_carry", {31'b0, out_carry}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("mid_rst_no_valid", {31'b0, out_valid}, 32'd0);
        end
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
